// File: rtl/core_fpu_pkg.sv
// Shared definitions for the FP execute sequencer: result-mux selects,
// compare function codes, sequencer states and default unit latencies.
package core_fpu_pkg;

   localparam int DEF_ADD_LAT = 4;
   localparam int DEF_MUL_LAT = 3;
   localparam int DEF_DIV_LAT = 12;
   localparam int DEF_CMP_LAT = 1;
   localparam int DEF_CNT_W   = 5;

   // Writeback result mux select
   typedef enum logic [1:0] {
      SRC_ADD = 2'd0,
      SRC_MUL = 2'd1,
      SRC_DIV = 2'd2,
      SRC_CMP = 2'd3
   } wb_src_e;

   // Compare function, func3 encoding
   typedef enum logic [1:0] {
      CMP_FLE = 2'b00,
      CMP_FLT = 2'b01,
      CMP_FEQ = 2'b10
   } cmp_func_e;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WB   = 2'd2
   } seq_state_e;

   // Number of decoded op flags raised; anything other than one is not issuable
   function automatic logic [2:0] op_count(input logic [6:0] flags);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 7; i++) begin
         n = n + {2'b00, flags[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/core_fpu_lat_cnt.sv
// Loadable down-counter that times a unit's fixed latency.
// Clear and reset beat load, load beats decrement; it parks at zero.
module core_fpu_lat_cnt #(
   parameter int CNT_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_r;

   // Count register with clear/load/decrement priority
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != '0)) begin
         cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == '0);

endmodule

// File: rtl/core_fpu_seq.sv
// FP execute sequencer: accepts one decoded FP op, pulses the selected
// unit's start, times its latency and emits a one-cycle writeback.
// Optional build macro FPU_SEQ_PERF_EN adds busy/stall cycle counters.
module core_fpu_seq
   import core_fpu_pkg::*;
#(
   parameter int ADD_LAT = DEF_ADD_LAT,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT,
   parameter int CMP_LAT = DEF_CMP_LAT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ISSUE_VALID,
   input  logic        I_FADDS,
   input  logic        I_FSUBS,
   input  logic        I_FMULS,
   input  logic        I_FDIVS,
   input  logic        I_FEQS,
   input  logic        I_FLTS,
   input  logic        I_FLES,
   input  logic [4:0]  RD_NUM,
   input  logic        FLUSH,
   output logic        ISSUE_READY,
   output logic        ADD_START,
   output logic        ADD_SUB,
   output logic        MUL_START,
   output logic        DIV_START,
   output logic        CMP_START,
   output logic [1:0]  CMP_FUNC,
   output logic        WB_VALID,
   output logic [4:0]  WB_RD,
   output logic [1:0]  WB_SRC,
   output logic        BUSY,
   output logic [4:0]  PEND_RD,
   output logic        ILLEGAL
`ifdef FPU_SEQ_PERF_EN
   ,
   output logic [31:0] PERF_BUSY,
   output logic [31:0] PERF_STALL
`endif
);

   localparam logic [CNT_W-1:0] ADD_LD = CNT_W'(ADD_LAT - 1);
   localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CMP_LD = CNT_W'(CMP_LAT - 1);

   seq_state_e       state_r;
   logic [4:0]       pend_rd_r;
   wb_src_e          wb_src_r;
   logic             add_sub_r;
   cmp_func_e        cmp_func_r;
   logic             add_start_r;
   logic             mul_start_r;
   logic             div_start_r;
   logic             cmp_start_r;
   logic             illegal_r;

   logic [6:0]       flags_s;
   logic [2:0]       n_flags_s;
   logic             ready_s;
   logic             take_s;
   logic             accept_s;
   logic             multi_s;
   wb_src_e          sel_src_s;
   cmp_func_e        sel_func_s;
   logic [CNT_W-1:0] load_val_s;
   logic             cnt_clr_s;
   logic             cnt_dec_s;
   logic             cnt_zero_s;

   // Issue handshake, flag validation and unit/latency decode
   always_comb begin
      flags_s    = {I_FLES, I_FLTS, I_FEQS, I_FDIVS, I_FMULS, I_FSUBS, I_FADDS};
      n_flags_s  = op_count(flags_s);
      ready_s    = ((state_r == IDLE) || (state_r == WB)) && !FLUSH;
      take_s     = ISSUE_VALID && ready_s;
      accept_s   = take_s && (n_flags_s == 3'd1);
      multi_s    = take_s && (n_flags_s > 3'd1);
      sel_src_s  = SRC_ADD;
      load_val_s = ADD_LD;
      sel_func_s = CMP_FLE;
      if (I_FMULS) begin
         sel_src_s  = SRC_MUL;
         load_val_s = MUL_LD;
      end else if (I_FDIVS) begin
         sel_src_s  = SRC_DIV;
         load_val_s = DIV_LD;
      end else if (I_FEQS || I_FLTS || I_FLES) begin
         sel_src_s  = SRC_CMP;
         load_val_s = CMP_LD;
      end else begin
         sel_src_s  = SRC_ADD;
         load_val_s = ADD_LD;
      end
      if (I_FEQS) begin
         sel_func_s = CMP_FEQ;
      end else if (I_FLTS) begin
         sel_func_s = CMP_FLT;
      end else begin
         sel_func_s = CMP_FLE;
      end
      cnt_clr_s = FLUSH && (state_r == RUN);
      cnt_dec_s = (state_r == RUN);
   end

   core_fpu_lat_cnt #(
      .CNT_W (CNT_W)
   ) u_lat_cnt (
      .CLK      (CLK),
      .RST      (RST),
      .clr      (cnt_clr_s),
      .load     (accept_s),
      .load_val (load_val_s),
      .dec      (cnt_dec_s),
      .zero     (cnt_zero_s)
   );

   // Sequencer FSM with its registered strobes and latched op fields
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= IDLE;
         pend_rd_r   <= 5'd0;
         wb_src_r    <= SRC_ADD;
         add_sub_r   <= 1'b0;
         cmp_func_r  <= CMP_FLE;
         add_start_r <= 1'b0;
         mul_start_r <= 1'b0;
         div_start_r <= 1'b0;
         cmp_start_r <= 1'b0;
         illegal_r   <= 1'b0;
      end else begin
         add_start_r <= accept_s && (sel_src_s == SRC_ADD);
         mul_start_r <= accept_s && (sel_src_s == SRC_MUL);
         div_start_r <= accept_s && (sel_src_s == SRC_DIV);
         cmp_start_r <= accept_s && (sel_src_s == SRC_CMP);
         illegal_r   <= multi_s;
         if (accept_s) begin
            pend_rd_r  <= RD_NUM;
            wb_src_r   <= sel_src_s;
            add_sub_r  <= I_FSUBS;
            cmp_func_r <= sel_func_s;
         end else begin
            pend_rd_r  <= pend_rd_r;
            wb_src_r   <= wb_src_r;
            add_sub_r  <= add_sub_r;
            cmp_func_r <= cmp_func_r;
         end
         case (state_r)
            IDLE: state_r <= accept_s ? RUN : IDLE;
            RUN: begin
               if (FLUSH) begin
                  state_r <= IDLE;
               end else if (cnt_zero_s) begin
                  state_r <= WB;
               end else begin
                  state_r <= RUN;
               end
            end
            // The writeback in WB is already committed; a back-to-back accept re-arms RUN
            WB:      state_r <= accept_s ? RUN : IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   assign ISSUE_READY = ready_s;
   assign ADD_START   = add_start_r;
   assign ADD_SUB     = add_sub_r;
   assign MUL_START   = mul_start_r;
   assign DIV_START   = div_start_r;
   assign CMP_START   = cmp_start_r;
   assign CMP_FUNC    = cmp_func_r;
   assign WB_VALID    = (state_r == WB);
   assign WB_RD       = pend_rd_r;
   assign WB_SRC      = wb_src_r;
   assign BUSY        = (state_r != IDLE);
   assign PEND_RD     = pend_rd_r;
   assign ILLEGAL     = illegal_r;

`ifdef FPU_SEQ_PERF_EN
   logic [31:0] perf_busy_r;
   logic [31:0] perf_stall_r;

   // Free-running busy and decode-stall cycle counters, insensitive to FLUSH
   always_ff @(posedge CLK) begin
      if (RST) begin
         perf_busy_r  <= 32'd0;
         perf_stall_r <= 32'd0;
      end else begin
         perf_busy_r  <= perf_busy_r + {31'd0, (state_r != IDLE)};
         perf_stall_r <= perf_stall_r + {31'd0, (ISSUE_VALID && !ready_s)};
      end
   end

   assign PERF_BUSY  = perf_busy_r;
   assign PERF_STALL = perf_stall_r;
`endif

endmodule

// File: tb/tb_core_fpu_seq.sv
// Self-checking bench for core_fpu_seq: directed scenarios then random
// traffic, compared each cycle against a transaction-level model.
module tb_core_fpu_seq;

   localparam int ADD_LAT = 4;
   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 12;
   localparam int CMP_LAT = 1;

   localparam logic [6:0] F_ADD = 7'b0000001;
   localparam logic [6:0] F_SUB = 7'b0000010;
   localparam logic [6:0] F_MUL = 7'b0000100;
   localparam logic [6:0] F_DIV = 7'b0001000;
   localparam logic [6:0] F_EQ  = 7'b0010000;
   localparam logic [6:0] F_NONE = 7'b0000000;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ISSUE_VALID;
   logic [6:0]  flags;
   logic [4:0]  RD_NUM;
   logic        FLUSH;
   logic        ISSUE_READY, ADD_START, ADD_SUB, MUL_START, DIV_START, CMP_START;
   logic [1:0]  CMP_FUNC, WB_SRC;
   logic        WB_VALID, BUSY, ILLEGAL;
   logic [4:0]  WB_RD, PEND_RD;
`ifdef FPU_SEQ_PERF_EN
   logic [31:0] PERF_BUSY, PERF_STALL;
`endif

   core_fpu_seq #(
      .ADD_LAT (ADD_LAT), .MUL_LAT (MUL_LAT), .DIV_LAT (DIV_LAT), .CMP_LAT (CMP_LAT), .CNT_W (5)
   ) dut (
      .CLK (CLK), .RST (RST), .ISSUE_VALID (ISSUE_VALID),
      .I_FADDS (flags[0]), .I_FSUBS (flags[1]), .I_FMULS (flags[2]), .I_FDIVS (flags[3]),
      .I_FEQS (flags[4]), .I_FLTS (flags[5]), .I_FLES (flags[6]),
      .RD_NUM (RD_NUM), .FLUSH (FLUSH), .ISSUE_READY (ISSUE_READY),
      .ADD_START (ADD_START), .ADD_SUB (ADD_SUB), .MUL_START (MUL_START),
      .DIV_START (DIV_START), .CMP_START (CMP_START), .CMP_FUNC (CMP_FUNC),
      .WB_VALID (WB_VALID), .WB_RD (WB_RD), .WB_SRC (WB_SRC), .BUSY (BUSY),
      .PEND_RD (PEND_RD), .ILLEGAL (ILLEGAL)
`ifdef FPU_SEQ_PERF_EN
      , .PERF_BUSY (PERF_BUSY), .PERF_STALL (PERF_STALL)
`endif
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: one op in flight, finishing at an absolute cycle number
   bit          m_busy  = 1'b0;
   int          m_wb_at = -1;
   logic [4:0]  m_rd    = 5'd0;
   int          m_src   = 0;
   logic        m_sub   = 1'b0;
   int          m_func  = 0;
   int          m_start = -1;
   bit          m_ill   = 1'b0;
   int unsigned m_pbusy  = 0;
   int unsigned m_pstall = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: drive inputs, compare this cycle's outputs, advance the model
   task automatic step(input logic v, input logic [6:0] fl, input logic [4:0] rd,
                       input logic fsh, input logic r);
      bit exp_wb, exp_rdy;
      int pop, lat;
      @(negedge CLK);
      ISSUE_VALID = v; flags = fl; RD_NUM = rd; FLUSH = fsh; RST = r;
      #1;
      exp_wb  = m_busy && (cyc == m_wb_at);
      exp_rdy = (!m_busy || exp_wb) && !fsh;
      check_eq("ready",    {31'd0, ISSUE_READY}, {31'd0, exp_rdy});
      check_eq("busy",     {31'd0, BUSY},        {31'd0, m_busy});
      check_eq("wb_valid", {31'd0, WB_VALID},    {31'd0, exp_wb});
      check_eq("wb_rd",    {27'd0, WB_RD},       {27'd0, m_rd});
      check_eq("pend_rd",  {27'd0, PEND_RD},     {27'd0, m_rd});
      check_eq("wb_src",   {30'd0, WB_SRC},      m_src);
      check_eq("add_start",{31'd0, ADD_START},   {31'd0, (m_start == 0)});
      check_eq("mul_start",{31'd0, MUL_START},   {31'd0, (m_start == 1)});
      check_eq("div_start",{31'd0, DIV_START},   {31'd0, (m_start == 2)});
      check_eq("cmp_start",{31'd0, CMP_START},   {31'd0, (m_start == 3)});
      check_eq("illegal",  {31'd0, ILLEGAL},     {31'd0, m_ill});
      if (m_src == 0) check_eq("add_sub",  {31'd0, ADD_SUB}, {31'd0, m_sub});
      if (m_src == 3) check_eq("cmp_func", {30'd0, CMP_FUNC}, m_func);
`ifdef FPU_SEQ_PERF_EN
      check_eq("perf_busy",  PERF_BUSY,  m_pbusy);
      check_eq("perf_stall", PERF_STALL, m_pstall);
`endif
      pop = $countones(fl);
      if (r) begin
         m_busy = 1'b0; m_rd = 5'd0; m_src = 0; m_sub = 1'b0; m_func = 0;
         m_start = -1; m_ill = 1'b0; m_pbusy = 0; m_pstall = 0;
      end else begin
         m_pbusy  += (m_busy ? 1 : 0);
         m_pstall += ((v && !exp_rdy) ? 1 : 0);
         m_ill   = v && exp_rdy && (pop > 1);
         m_start = -1;
         if (v && exp_rdy && (pop == 1)) begin
            if (fl[0] || fl[1])  begin m_src = 0; lat = ADD_LAT; end
            else if (fl[2])      begin m_src = 1; lat = MUL_LAT; end
            else if (fl[3])      begin m_src = 2; lat = DIV_LAT; end
            else                 begin m_src = 3; lat = CMP_LAT; end
            m_sub   = fl[1];
            m_func  = fl[4] ? 2 : (fl[5] ? 1 : 0);
            m_rd    = rd;
            m_busy  = 1'b1;
            m_wb_at = cyc + 1 + lat;
            m_start = m_src;
         end else if (exp_wb || (m_busy && fsh)) begin
            m_busy = 1'b0;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, F_NONE, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [6:0] fl;
      int a, b, k;
      RST = 1'b1; ISSUE_VALID = 1'b0; flags = F_NONE; RD_NUM = 5'd0; FLUSH = 1'b0;
      repeat (2) @(posedge CLK);
      idle(2);
      // Single FMUL.S to f7
      step(1'b1, F_MUL, 5'd7, 1'b0, 1'b0);
      idle(5);
      // FSUB.S, then FEQ.S held until it is taken in the WB cycle
      step(1'b1, F_SUB, 5'd3, 1'b0, 1'b0);
      for (int i = 0; i < ADD_LAT + 1; i++) step(1'b1, F_EQ, 5'd9, 1'b0, 1'b0);
      idle(3);
      // FDIV.S flushed five cycles later
      step(1'b1, F_DIV, 5'd12, 1'b0, 1'b0);
      idle(4);
      step(1'b0, F_NONE, 5'd0, 1'b1, 1'b0);
      idle(2);
      // Multi-hot flags
      step(1'b1, F_ADD | F_MUL, 5'd4, 1'b0, 1'b0);
      idle(2);
      // Reset during FDIV.S, f0 destination
      step(1'b1, F_DIV, 5'd0, 1'b0, 1'b0);
      idle(5);
      step(1'b0, F_NONE, 5'd0, 1'b0, 1'b1);
      idle(2);
      // Three back-to-back FMUL.S with ISSUE_VALID held
      for (int i = 0; i < 3 * (MUL_LAT + 1) - 3; i++) step(1'b1, F_MUL, 5'd21, 1'b0, 1'b0);
      idle(4);
      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         k = $urandom_range(0, 9);
         if (k == 0) begin
            fl = F_NONE;
         end else if (k == 1) begin
            a  = $urandom_range(0, 6);
            b  = (a + 1 + $urandom_range(0, 5)) % 7;
            fl = (7'd1 << a) | (7'd1 << b);
         end else begin
            fl = 7'd1 << $urandom_range(0, 6);
         end
         step($urandom_range(0, 1) == 1, fl, 5'($urandom_range(0, 31)),
              $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
